// File: rtl/fixed_fp_pkg.sv
// Shared constants and stage payload for the fixed-point to binary32 converter.
package fixed_fp_pkg;

  localparam int unsigned FP32_BIAS  = 127;
  localparam int unsigned FP32_MAN_W = 23;
  localparam int unsigned FP32_EXP_W = 8;

  // Magnitude is left-aligned into a fixed 32-bit field so the payload is parameter-independent
  localparam int unsigned NORM_W = 32;
  localparam int unsigned LZC_W  = 6;

  typedef struct packed {
    logic              sign;
    logic [LZC_W-1:0]  lzc;
    logic [NORM_W-1:0] mag;
    logic              valid;
  } stage_t;

endpackage

// File: rtl/lzc.sv
// Leading-zero counter with all-zero flag; count equals W when the input is zero.
module lzc #(
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     data_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  // Scan upward so the highest set bit determines the count
  always_comb begin
    cnt_o = CNT_W'(W);
    for (int unsigned i = 0; i < W; i++) begin
      if (data_i[i]) cnt_o = CNT_W'(W - 1 - i);
    end
  end

  assign zero_o = ~|data_i;

endmodule

// File: rtl/fixed_to_fp_pipe.sv
// Three-stage fixed-point to IEEE-754 binary32 converter with valid/ready flow control.
// Define FIXED_TO_FP_RNE_EN for round-to-nearest-even; default build truncates toward zero.
module fixed_to_fp_pipe
  import fixed_fp_pkg::*;
#(
  parameter int unsigned IN_W   = 18,
  parameter int unsigned FRAC_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_signed,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data,
  output logic            out_inexact
);

  // Biased exponent when the magnitude's top bit (IN_W-1) is the leading one
  localparam int unsigned EXP_TOP = FP32_BIAS + IN_W - 1 - FRAC_W;
  localparam int unsigned MAN_HI  = NORM_W - 2;
  localparam int unsigned G_IDX   = NORM_W - 2 - FP32_MAN_W;

  logic stall_c;

  logic            s1_valid_q, s1_sign_q, s1_sign_d;
  logic [IN_W-1:0] s1_mag_q, s1_mag_d;

  logic [NORM_W-1:0] mag_ext;
  logic [LZC_W-1:0]  lzc_cnt;
  logic              lzc_zero;
  stage_t            s2_q, s2_d;

  logic [FP32_MAN_W-1:0] man_d;
  logic [FP32_EXP_W-1:0] exp_d;
  logic                  inexact_d;
  logic [31:0]           data_d;

  logic        out_valid_q;
  logic [31:0] out_data_q;
  logic        out_inexact_q;

  assign stall_c     = out_valid_q & ~out_ready;
  assign in_ready    = ~stall_c;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_inexact = out_inexact_q;

  // S1: sign extraction and IN_W-bit unsigned magnitude
  always_comb begin
    s1_sign_d = in_signed & in_data[IN_W-1];
    s1_mag_d  = s1_sign_d ? IN_W'(~in_data + 1'b1) : in_data;
  end

  // S1 register
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_mag_q   <= '0;
    end else if (!stall_c) begin
      s1_valid_q <= in_valid;
      s1_sign_q  <= s1_sign_d;
      s1_mag_q   <= s1_mag_d;
    end
  end

  assign mag_ext = NORM_W'(s1_mag_q) << (NORM_W - IN_W);

  lzc #(.W(NORM_W), .CNT_W(LZC_W)) u_lzc (
    .data_i (mag_ext),
    .cnt_o  (lzc_cnt),
    .zero_o (lzc_zero)
  );

  // S2: left-normalise so the leading one lands in the top bit
  always_comb begin
    s2_d       = '0;
    s2_d.sign  = s1_sign_q & ~lzc_zero;
    s2_d.lzc   = lzc_cnt;
    s2_d.mag   = mag_ext << lzc_cnt;
    s2_d.valid = s1_valid_q;
  end

  // S2 register
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_q <= '0;
    end else if (!stall_c) begin
      s2_q <= s2_d;
    end
  end

  // S3: rounding, exponent adjustment and packing
  always_comb begin
    man_d     = s2_q.mag[MAN_HI -: FP32_MAN_W];
    exp_d     = FP32_EXP_W'(EXP_TOP) - FP32_EXP_W'(s2_q.lzc);
    inexact_d = |s2_q.mag[G_IDX:0];
`ifdef FIXED_TO_FP_RNE_EN
    begin
      logic                round_up;
      logic [FP32_MAN_W:0] man_sum;
      round_up = s2_q.mag[G_IDX] &
                 (s2_q.mag[G_IDX-1] | (|s2_q.mag[G_IDX-2:0]) | s2_q.mag[G_IDX+1]);
      man_sum  = {1'b0, man_d} + (FP32_MAN_W + 1)'(round_up);
      // Carry out of the mantissa leaves it zero and bumps the exponent
      man_d    = man_sum[FP32_MAN_W-1:0];
      exp_d    = exp_d + FP32_EXP_W'(man_sum[FP32_MAN_W]);
    end
`endif
    data_d = s2_q.mag[NORM_W-1] ? {s2_q.sign, exp_d, man_d} : 32'h0000_0000;
    if (!s2_q.mag[NORM_W-1]) inexact_d = 1'b0;
  end

  // S3 output register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_inexact_q <= 1'b0;
    end else if (!stall_c) begin
      out_valid_q   <= s2_q.valid;
      out_data_q    <= data_d;
      out_inexact_q <= inexact_d;
    end
  end

endmodule

// File: tb/tb_fixed_to_fp_pipe.sv
// Bench for fixed_to_fp_pipe: default instance (18/16) and a 32/0 instance, scoreboard checked.
module tb_fixed_to_fp_pipe;

`ifdef FIXED_TO_FP_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  localparam int AW = 18, AF = 16, BW = 32, BF = 0;

  typedef struct {
    logic [31:0] d;
    logic        x;
    int          cyc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  logic          a_in_valid, a_in_ready, a_in_signed, a_out_valid, a_out_ready, a_out_inexact;
  logic [AW-1:0] a_in_data;
  logic [31:0]   a_out_data;
  logic          b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready, b_out_inexact;
  logic [BW-1:0] b_in_data;
  logic [31:0]   b_out_data;

  logic [31:0] a_exp_d, b_exp_d;
  logic        a_exp_x, b_exp_x;
  bit          a_exp_lat, b_exp_lat;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fixed_to_fp_pipe #(.IN_W(AW), .FRAC_W(AF)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_signed(a_in_signed), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_inexact(a_out_inexact)
  );

  fixed_to_fp_pipe #(.IN_W(BW), .FRAC_W(BF)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_signed(b_in_signed), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_inexact(b_out_inexact)
  );

  // Reference conversion: {inexact, binary32} via remainder comparison
  function automatic logic [32:0] model(input logic [31:0] raw, input int iw, input int fw,
                                        input bit sgn, input bit rne);
    logic [63:0] mask, v, kept, rem, half;
    bit neg, inx;
    int msb, sh, e;
    mask = (64'd1 << iw) - 64'd1;
    v    = {32'd0, raw} & mask;
    neg  = sgn && v[iw-1];
    if (neg) v = (~v + 64'd1) & mask;
    if (v == 64'd0) return 33'd0;
    msb = 0;
    for (int i = 0; i < 64; i++) if (v[i]) msb = i;
    e   = msb - fw + 127;
    inx = 1'b0;
    if (msb <= 23) begin
      kept = v << (23 - msb);
    end else begin
      sh   = msb - 23;
      kept = v >> sh;
      rem  = v & ((64'd1 << sh) - 64'd1);
      inx  = (rem != 64'd0);
      half = 64'd1 << (sh - 1);
      if (rne && (rem > half || (rem == half && kept[0]))) kept = kept + 64'd1;
      if (kept[24]) begin
        kept = kept >> 1;
        e    = e + 1;
      end
    end
    return {inx, neg, 8'(e), kept[22:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic pop_check(inout exp_t q[$], input string tag, input logic [31:0] d,
                           input logic x);
    exp_t e;
    n_assert++;
    assert (q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s_unexpected_output observed=0x%08h expected=none", tag, d);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, "_data"}, d, e.d);
      chk({tag, "_inexact"}, 32'(x), 32'(e.x));
      if (e.lat) chk({tag, "_latency"}, 32'(cyc - e.cyc), 32'd3);
    end
  endtask

  // Monitor A: scoreboard push/pop plus stall-hold checks, sampled on the falling edge
  task automatic mon_a();
    bit          pst = 1'b0;
    logic [31:0] hd = '0;
    logic        hx = 1'b0;
    forever begin
      @(negedge clk);
      if (pst) begin
        chk("a_hold_valid", 32'(a_out_valid), 32'd1);
        chk("a_hold_data", a_out_data, hd);
        chk("a_hold_inexact", 32'(a_out_inexact), 32'(hx));
      end
      if (a_out_valid && !a_out_ready) chk("a_stall_in_ready", 32'(a_in_ready), 32'd0);
      pst = a_out_valid && !a_out_ready;
      hd  = a_out_data;
      hx  = a_out_inexact;
      if (a_in_valid && a_in_ready && !rst) qa.push_back('{a_exp_d, a_exp_x, cyc, a_exp_lat});
      if (a_out_valid && a_out_ready) pop_check(qa, "a", a_out_data, a_out_inexact);
    end
  endtask

  task automatic mon_b();
    forever begin
      @(negedge clk);
      if (b_in_valid && b_in_ready && !rst) qb.push_back('{b_exp_d, b_exp_x, cyc, b_exp_lat});
      if (b_out_valid && b_out_ready) pop_check(qb, "b", b_out_data, b_out_inexact);
    end
  endtask

  task automatic send_a(input logic [AW-1:0] d, input bit s, input logic [31:0] ed,
                        input bit ex, input bit lat);
    bit ok;
    int n = 0;
    a_in_valid = 1'b1; a_in_data = d; a_in_signed = s;
    a_exp_d = ed; a_exp_x = ex; a_exp_lat = lat;
    do begin
      @(negedge clk);
      ok = a_in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 64);
    a_in_valid = 1'b0;
    chk("a_accept", 32'(ok), 32'd1);
  endtask

  task automatic send_b(input logic [BW-1:0] d, input bit s, input logic [31:0] ed,
                        input bit ex, input bit lat);
    bit ok;
    int n = 0;
    b_in_valid = 1'b1; b_in_data = d; b_in_signed = s;
    b_exp_d = ed; b_exp_x = ex; b_exp_lat = lat;
    do begin
      @(negedge clk);
      ok = b_in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 64);
    b_in_valid = 1'b0;
    chk("b_accept", 32'(ok), 32'd1);
  endtask

  task automatic send_a_model(input logic [AW-1:0] d, input bit s, input bit lat);
    logic [32:0] m;
    m = model(32'(d), AW, AF, s, RNE);
    send_a(d, s, m[31:0], m[32], lat);
  endtask

  task automatic send_b_model(input logic [BW-1:0] d, input bit s);
    logic [32:0] m;
    m = model(d, BW, BF, s, RNE);
    send_b(d, s, m[31:0], m[32], 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", 32'(qa.size() + qb.size()), 32'd0);
  endtask

  // Hard stop if the sequence ever wedges
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_signed = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_signed = 1'b0; b_out_ready = 1'b1;
    a_exp_d = '0; a_exp_x = 1'b0; a_exp_lat = 1'b0;
    b_exp_d = '0; b_exp_x = 1'b0; b_exp_lat = 1'b0;
    fork
      mon_a();
      mon_b();
    join_none
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_a_out_data", a_out_data, 32'd0);
    chk("rst_a_out_inexact", 32'(a_out_inexact), 32'd0);
    chk("rst_a_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);

    // Default parameters, signed operands
    send_a(18'h10000, 1'b1, 32'h3F80_0000, 1'b0, 1'b1);
    send_a(18'h20000, 1'b1, 32'hC000_0000, 1'b0, 1'b1);
    send_a(18'h00001, 1'b1, 32'h3780_0000, 1'b0, 1'b1);
    send_a(18'h00000, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
    // Default parameters, unsigned operands
    send_a(18'h20000, 1'b0, 32'h4000_0000, 1'b0, 1'b1);
    send_a(18'h3FFFF, 1'b0, 32'h407F_FFC0, 1'b0, 1'b1);
    send_a(18'h3FFFF, 1'b1, 32'hB780_0000, 1'b0, 1'b1);

    // 32-bit integer instance: rounding boundaries
    send_b(32'h0100_0003, 1'b0, RNE ? 32'h4B80_0002 : 32'h4B80_0001, 1'b1, 1'b1);
    send_b(32'h0100_0001, 1'b0, 32'h4B80_0000, 1'b1, 1'b1);
    send_b(32'h01FF_FFFF, 1'b0, RNE ? 32'h4C00_0000 : 32'h4BFF_FFFF, 1'b1, 1'b1);
    send_b(32'h8000_0000, 1'b1, 32'hCF00_0000, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) send_b_model(32'($urandom), 1'($urandom));
    drain();

    // Back-to-back stream of 8 with a 4-cycle downstream stall mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++)
          send_a_model(18'({3'(i), 15'($urandom)}), 1'($urandom), 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        a_out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        a_out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two items in flight
    send_a(18'h10000, 1'b1, 32'h3F80_0000, 1'b0, 1'b0);
    send_a(18'h20000, 1'b0, 32'h4000_0000, 1'b0, 1'b0);
    rst = 1'b1;
    qa.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("inflight_rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("inflight_rst_out_data", a_out_data, 32'd0);
    chk("inflight_rst_in_ready", 32'(a_in_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_stale", 32'(a_out_valid), 32'd0);
    end
    send_a_model(18'h18000, 1'b0, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
